// File: rtl/fm_fast_memory_if.sv
// ---------------------------------------------------------------------------
// fm_fast_memory_if : port bundle for the EBOX fast-memory (AC) register file.
//
// Signals (PDP-10 numbering, bit 0 = MSB):
//   addra [0:ADDR_WIDTH-1] word address {FM block, AC address}
//   dina  [0:DATA_WIDTH-1] write data from AR
//   wea   [0:LANES-1]      lane write enables, lane 0 = bits 0-8
//   douta [0:DATA_WIDTH-1] registered read data to ADB / EBUS diag / parity
//
// Modports:
//   master : EBOX side, drives address/data/enables and receives read data
//   slave  : memory side
// ---------------------------------------------------------------------------
interface fm_fast_memory_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 36,
  parameter int LANES      = 4
);
  logic [0:ADDR_WIDTH-1] addra;
  logic [0:DATA_WIDTH-1] dina;
  logic [0:LANES-1]      wea;
  logic [0:DATA_WIDTH-1] douta;

  modport master (
    output addra,
    output dina,
    output wea,
    input  douta
  );

  modport slave (
    input  addra,
    input  dina,
    input  wea,
    output douta
  );
endinterface

// File: rtl/fm_fast_memory.sv
// ---------------------------------------------------------------------------
// fm_fast_memory : EBOX fast-memory (AC) register file, 128 x 36 bits as
// 8 AC blocks of 16 words. Single-port block RAM with 9-bit lane write
// enables, write-first read behaviour and a synchronously reset output
// register (read latency exactly one clock).
//
// Ports:
//   clka : clock, all state changes on the rising edge
//   rsta : synchronous active-high reset; clears douta and suppresses writes,
//          array contents are kept
//   bus  : fm_fast_memory_if.slave (addra, dina, wea in; douta out)
// ---------------------------------------------------------------------------
module fm_fast_memory #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 36,
  parameter int LANES      = 4
) (
  input  logic               clka,
  input  logic               rsta,
  fm_fast_memory_if.slave    bus
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int LANE_W = DATA_WIDTH / LANES;

  // Power-up/configuration contents are all zero; the declaration initialiser
  // becomes the block RAM init image.
  // NOTE: the array is deliberately left out of rsta -- a block RAM cannot be
  // cleared in one cycle, and the AC contents must survive an EBOX reset.
  logic [0:DATA_WIDTH-1] mem [0:DEPTH-1] = '{default: '0};

  logic [0:DATA_WIDTH-1] rd_word;
  logic [0:DATA_WIDTH-1] merged;

  // Write-first view of the addressed word: enabled lanes show the incoming
  // data, the rest show the stored contents.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals (no latches).
    rd_word = mem[bus.addra];
    merged  = rd_word;
    for (int k = 0; k < LANES; k++) begin
      if (bus.wea[k]) begin
        merged[k*LANE_W +: LANE_W] = bus.dina[k*LANE_W +: LANE_W];
      end
    end
  end

  // Array write port: lanes are independent, no pairing is assumed.
  always_ff @(posedge clka) begin
    // NOTE: non-blocking assignments for all clocked state so every
    // register samples pre-edge values regardless of statement order.
    if (!rsta) begin
      for (int k = 0; k < LANES; k++) begin
        if (bus.wea[k]) begin
          mem[bus.addra][k*LANE_W +: LANE_W] <= bus.dina[k*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Output register with synchronous reset; the only path to douta.
  always_ff @(posedge clka) begin
    if (rsta) begin
      bus.douta <= '0;
    end else begin
      bus.douta <= merged;
    end
  end

endmodule

// File: tb/tb_fm_fast_memory.sv
// ---------------------------------------------------------------------------
// tb_fm_fast_memory : self-checking bench for fm_fast_memory. Directed cases
// plus randomized traffic, checked against an array-based reference model
// that applies lane masks arithmetically to whole words.
// ---------------------------------------------------------------------------
module tb_fm_fast_memory;

  logic clka = 1'b0;
  logic rsta;

  fm_fast_memory_if #(.ADDR_WIDTH(7), .DATA_WIDTH(36), .LANES(4)) bus ();

  fm_fast_memory #(.ADDR_WIDTH(7), .DATA_WIDTH(36), .LANES(4)) dut (
    .clka (clka),
    .rsta (rsta),
    .bus  (bus)
  );

  always #5 clka = ~clka;

  int errors = 0;
  int checks = 0;

  // Reference model: numeric MSB of each value corresponds to PDP-10 bit 0.
  logic [35:0] ref_mem [128];
  logic [35:0] obs;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %012o want %012o", tag, got, want);
    end
  endtask

  // w[3] is lane 0 (bits 0-8, the numerically highest 9 bits).
  function automatic logic [35:0] lane_mask(input logic [3:0] w);
    return {{9{w[3]}}, {9{w[2]}}, {9{w[1]}}, {9{w[0]}}};
  endfunction

  // One clock: drive at the falling edge, predict, clock, sample 1 ns later.
  task automatic cycle(input string tag, input logic r, input logic [6:0] a,
                       input logic [3:0] w, input logic [35:0] d);
    logic [35:0] want;
    logic [35:0] m;
    rsta      = r;
    bus.addra = a;
    bus.wea   = w;
    bus.dina  = d;
    m = lane_mask(w);
    if (r) begin
      want = '0;
    end else begin
      want = (ref_mem[a] & ~m) | (d & m);
      ref_mem[a] = want;
    end
    @(posedge clka);
    #1;
    obs = bus.douta;
    check(tag, obs, want);
    @(negedge clka);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    rsta = 1'b1; bus.addra = '0; bus.wea = '0; bus.dina = '0;
    @(negedge clka);

    // Reset with an active write: output held at zero, write suppressed.
    for (int i = 0; i < 3; i++) begin
      cycle("rst_hold", 1'b1, 7'd5, 4'b1111, 36'o123456701234);
      check("rst_zero", obs, 36'o0);
    end
    cycle("rst_rd5", 1'b0, 7'd5, 4'b0000, 36'o0);
    check("rst_suppressed", obs, 36'o0);

    // Full-word writes and readback, including the two extreme addresses.
    cycle("wr00", 1'b0, 7'h00, 4'b1111, 36'o777000777000);
    cycle("wr7f", 1'b0, 7'h7F, 4'b1111, 36'o001002003004);
    cycle("wr10", 1'b0, 7'h10, 4'b1111, 36'o525252525252);
    cycle("rd00", 1'b0, 7'h00, 4'b0000, 36'o0);
    check("rd00_const", obs, 36'o777000777000);
    cycle("rd7f", 1'b0, 7'h7F, 4'b0000, 36'o0);
    check("rd7f_const", obs, 36'o001002003004);
    cycle("rd10", 1'b0, 7'h10, 4'b0000, 36'o0);
    check("rd10_const", obs, 36'o525252525252);
    cycle("rd00_again", 1'b0, 7'h00, 4'b0000, 36'o0);
    check("no_alias_00_7f", obs, 36'o777000777000);

    // Lane writes.
    cycle("pre3", 1'b0, 7'd3, 4'b1111, 36'o111111111111);
    cycle("lane_hi", 1'b0, 7'd3, 4'b1100, 36'o777777777777);
    check("lane_hi_merge", obs, 36'o777777111111);
    cycle("lane_3", 1'b0, 7'd3, 4'b0001, 36'o0);
    check("lane_3_merge", obs, 36'o777777111000);
    cycle("rd3", 1'b0, 7'd3, 4'b0000, 36'o0);
    check("rd3_const", obs, 36'o777777111000);

    // Write-first on a half-word write to a never-written word.
    cycle("wf9", 1'b0, 7'd9, 4'b0011, 36'o444444444444);
    check("wf9_same_edge", obs, 36'o000000444444);
    cycle("wf9_rd", 1'b0, 7'd9, 4'b0000, 36'o0);
    check("wf9_next", obs, 36'o000000444444);

    // Reset in mid-stream keeps contents and suppresses the write.
    cycle("wr20", 1'b0, 7'd20, 4'b1111, 36'o246);
    cycle("rst20", 1'b1, 7'd20, 4'b1111, 36'o0);
    check("rst20_zero", obs, 36'o0);
    cycle("rd20", 1'b0, 7'd20, 4'b0000, 36'o0);
    check("rd20_retained", obs, 36'o246);

    // Sweep: each word holds its index in every lane.
    for (int a = 0; a < 128; a++) begin
      logic [8:0] idx;
      idx = 9'(a);
      cycle("sweep_wr", 1'b0, 7'(a), 4'b1111, {4{idx}});
    end
    for (int a = 0; a < 128; a++) begin
      logic [8:0] idx;
      idx = 9'(a);
      cycle("sweep_rd", 1'b0, 7'(a), 4'b0000, 36'o0);
      check("sweep_pattern", obs, {4{idx}});
    end

    // Randomized traffic against the model, occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic        r;
      logic [6:0]  a;
      logic [3:0]  w;
      logic [35:0] d;
      r = ($urandom_range(0, 31) == 0);
      a = 7'($urandom_range(0, 127));
      w = 4'($urandom_range(0, 15));
      d = {4'($urandom), 32'($urandom)};
      cycle("rand", r, a, w, d);
    end

    // Final readback of the whole array.
    for (int a = 0; a < 128; a++) begin
      cycle("final_rd", 1'b0, 7'(a), 4'b0000, 36'o0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fm_fast_memory.md
Name: fm_fast_memory

Overview:
- Fast-memory (AC) register file for the EBOX data path: 128 words x 36 bits, organised as 8 AC blocks of 16 words.
- Address is {FM block[0:2], AC address[0:3]}.
- Write data comes from AR, with independent half-word write enables (two lanes per half).
- Read data feeds the ADB mux, the EBUS diag mux and the parity tree; it is registered with single-cycle latency, block-RAM style.

Parameters:
- ADDR_WIDTH, 7, address bits; depth = 2**ADDR_WIDTH = 128 words.
- DATA_WIDTH, 36, word width; bit 0 = MSB (PDP-10 numbering [0:35]).
- LANES, 4, write-enable lanes; each covers DATA_WIDTH/LANES = 9 bits.

Ports:
- clka  input  1  clock; all state changes on its rising edge.
- rsta  input  1  synchronous active-high reset.
- addra  input  7  [0:6] word address; bit 0 = MSB of block number.
- dina  input  36  [0:35] write data.
- wea  input  4  [0:3] lane write enables: wea[0]->bits 0-8, wea[1]->9-17, wea[2]->18-26, wea[3]->27-35.
- douta  output  36  [0:35] registered read data.

Behaviour:
- Storage: 128 x 36 array, all words zero at power-up/configuration. rsta does NOT clear array contents.
- Reset:
  - rsta=1 at a rising edge: douta <= 0 and all writes in that cycle are suppressed.
  - douta stays 0 every cycle rsta is held.
  - First read after release returns the addressed word one edge after rsta deasserts.
- Read:
  - At each rising edge with rsta=0: douta <= mem[addra], with write-first per-lane merging (below).
  - Latency is exactly 1 clock. douta holds between edges.
  - No read enable: a read occurs every cycle.
- Write:
  - At a rising edge with rsta=0, for each lane k with wea[k]=1: mem[addra][9k:9k+8] <= dina[9k:9k+8].
  - Lanes with wea[k]=0 keep their old contents.
  - Any combination of the 4 enables is legal, including 0000 (pure read) and 1111 (full word).
  - The EBOX drives wea as {wr00_17, wr00_17, wr18_35, wr18_35}, but the block does not assume lane pairing.
- Write-first merge: in a write cycle, douta lane k = dina lane k if wea[k]=1, else old mem[addra] lane k. A read-modify-write of one half-word therefore shows the merged word immediately.
- Address wrap: none needed; all 128 addresses are valid, and address 127 and address 0 are independent.
- Back-to-back:
  - Write at A in cycle n, read A in cycle n+1: returns the cycle-n data (no extra hazard cycle).
  - Consecutive writes to different addresses are each one cycle.
- X-handling: X on addra or wea while rsta=0 is a user error; the block makes no guarantee.
- Implementation: must infer a single-port block RAM with byte(9-bit)-lane write enables and an output register with synchronous reset. No latches. No combinational path from any input to douta.

Test Plan:
- Reset: hold rsta=1 for 3 cycles with wea=1111, addra=5, dina=36'o123456701234 -> douta=0 throughout. After release, read addr 5 -> 0, proving the write was suppressed.
- Full write/readback:
  - Write 36'o777000777000 to addr 0x00, 36'o001002003004 to 0x7F, and 36'o525252525252 to 0x10, with wea=1111.
  - Read each with wea=0000 -> exact values one cycle after the address is presented.
  - Also check that 0x00 and 0x7F do not alias.
- Lane writes:
  - Preload addr 3 with 36'o111111111111.
  - Write dina=36'o777777777777, wea=1100 -> readback 36'o777777111111.
  - Then wea=0001 with dina=0 -> 36'o777777111000.
- Write-first: write addr 9 (old 36'o0) with wea=0011, dina=36'o444444444444 -> douta in that same edge's output = 36'o000000444444. Next cycle with wea=0000 -> same value.
- Reset mid-stream:
  - Write addr 20=36'o246, then assert rsta for 1 cycle while presenting addra=20, wea=1111, dina=36'o0 -> douta=0.
  - After release, read 20 -> 36'o246 (contents retained, write suppressed).
- Sweep: write each address a = its own index replicated into all lanes, then read all 128 sequentially -> each douta equals the expected pattern at latency 1, with no stale or shifted data.
